sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream stage of the dual-width hierarchical adder.
- Consumes the 17-bit sum S, the 9-bit sum T and the combined overflow flag through a valid/ready handshake.
- Accumulates a block of COUNT_N sample pairs into wider accumulators, then presents the totals with a sticky overflow indication.
- Output feeds the statistics/readout logic.

Parameters:
- WA, 17, width of input sum S (unsigned, carry included).
- WB, 9, width of input sum T (unsigned, carry included).
- ACC_WA, 24, width of the S accumulator; must be >= WA.
- ACC_WB, 16, width of the T accumulator; must be >= WB.
- COUNT_N, 16, samples per block; range 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage can accept a sample.
- s_in  in  WA  sum S.
- t_in  in  WB  sum T.
- ovf_in  in  1  adder overflow flag for this sample.
- clear  in  1  synchronous abort of the current block.
- out_valid  out  1  block result valid.
- out_ready  in  1  consumer accepts the result.
- acc_s  out  ACC_WA  accumulated S.
- acc_t  out  ACC_WB  accumulated T.
- ovf_sticky  out  1  OR of ovf_in over the block.
- acc_limit  out  1  an accumulator reached its limit (saturated or wrapped).

Behaviour:
- Reset: all registered state resets on the clk edge when rst_n=0. Takes priority over everything, including mid-block and mid-HOLD.
  - Reset values: state=IDLE, sample count=0, acc_s=0, acc_t=0, ovf_sticky=0, acc_limit=0, out_valid=0.
- Handshake and in_ready:
  - A sample transfers on a cycle with in_valid & in_ready. A result transfers on out_valid & out_ready.
  - in_ready=1 in IDLE and ACCUM, 0 in HOLD. It is registered state only; it never depends on out_ready combinationally.
- States:
  - IDLE: accumulators read zero. A transfer loads acc_s=s_in, acc_t=t_in, ovf_sticky=ovf_in, count=1. Next state is ACCUM, or HOLD if COUNT_N=1.
  - ACCUM: each transfer adds zero-extended s_in/t_in into the accumulators, ORs ovf_in into ovf_sticky and increments count. The transfer that makes count==COUNT_N goes to HOLD. Cycles without a transfer leave all state unchanged.
  - HOLD: out_valid=1. acc_s, acc_t, ovf_sticky and acc_limit are held stable until out_ready=1. On that cycle, go to IDLE, clear all accumulator state and drop out_valid the next cycle.
- Latency: out_valid rises the cycle after the COUNT_N-th input transfer.
- Throughput: one block per COUNT_N+1 cycles minimum, since at least one HOLD cycle is needed.
- clear:
  - In IDLE/ACCUM it discards the partial block and returns to IDLE with zeroed state; a sample presented that cycle is dropped.
  - In HOLD it is ignored, so a pending result is never lost.
- Arithmetic: unsigned. acc_limit is sticky per block.
- Simultaneous in_valid and out_ready in HOLD: the result transfers, the input is not accepted (in_ready=0), and the input is accepted from the following cycle.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SAT_EN.
- Defined: each accumulator saturates at 2^ACC_W-1. Any add that would exceed the maximum clamps to it and sets acc_limit.
- Undefined: accumulators wrap modulo 2^ACC_W. acc_limit is set on the carry-out of any add. Saturation logic is not synthesized.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Default widths WA=17, WB=9, so the adder and this stage agree.
- One natural sub-module: sat_add, parameterised width W.
  - Inputs: acc[W-1:0] and a zero-extended operand.
  - Outputs: next value and a limit flag.
  - Saturate or wrap under the macro.
  - Instantiated twice (S path and T path).

Test Plan:
- COUNT_N=4, in_valid held high, s_in=1000, t_in=10, ovf_in=0, out_ready=1 -> out_valid one cycle after the 4th transfer, acc_s=4000, acc_t=40, ovf_sticky=0, acc_limit=0; in_ready=0 for exactly one cycle.
- COUNT_N=4, ovf_in=1 only on sample 2 -> ovf_sticky=1 in the result; the next block with no ovf_in reports ovf_sticky=0.
- ACC_WB=9, COUNT_N=4, t_in=511 -> macro defined: acc_t=511, acc_limit=1; macro undefined: acc_t=(4*511) mod 512=508, acc_limit=1.
- COUNT_N=4, out_ready=0 for 10 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, no samples consumed; out_ready=1 -> result taken, next block starts the following cycle.
- clear asserted after 2 of 4 samples -> state IDLE, accumulators 0; next 4 samples of 5 -> acc_s=20.
- rst_n=0 for one cycle in mid-ACCUM and again in HOLD -> all outputs at reset values next cycle; out_valid=0, in_ready=1.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: state encoding and default sum widths shared with the upstream adder
package sum_accumulator_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_e;
    localparam int DEF_WA = 17;
    localparam int DEF_WB = 9;
    localparam int CNT_W = 16;
endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample input and block result handshakes of the accumulator stage
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int WA = DEF_WA,
    parameter int WB = DEF_WB,
    parameter int ACC_WA = 24,
    parameter int ACC_WB = 16
);
    logic in_valid;
    logic in_ready;
    logic [WA-1:0] s_in;
    logic [WB-1:0] t_in;
    logic ovf_in;
    logic clear;
    logic out_valid;
    logic out_ready;
    logic [ACC_WA-1:0] acc_s;
    logic [ACC_WB-1:0] acc_t;
    logic ovf_sticky;
    logic acc_limit;
    modport master (
        output in_valid, s_in, t_in, ovf_in, clear, out_ready,
        input in_ready, out_valid, acc_s, acc_t, ovf_sticky, acc_limit
    );
    modport slave (
        input in_valid, s_in, t_in, ovf_in, clear, out_ready,
        output in_ready, out_valid, acc_s, acc_t, ovf_sticky, acc_limit
    );
endinterface

// File: rtl/sum_accumulator_sat_add.sv
// sat_add: accumulator adder; saturates when SUM_ACCUMULATOR_SAT_EN is defined, otherwise wraps
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] opd_i,
    output logic [W-1:0] sum_o,
    output logic         lim_o
);
    logic [W:0] raw;
    assign raw = {1'b0, acc_i} + {1'b0, opd_i};
    assign lim_o = raw[W];
`ifdef SUM_ACCUMULATOR_SAT_EN
    assign sum_o = raw[W] ? '1 : raw[W-1:0];
`else
    assign sum_o = raw[W-1:0];
`endif
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT_N (S, T) samples per block with sticky overflow/limit flags
// SUM_ACCUMULATOR_SAT_EN selects saturating instead of wrapping accumulators
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int WA = DEF_WA,
    parameter int WB = DEF_WB,
    parameter int ACC_WA = 24,
    parameter int ACC_WB = 16,
    parameter int COUNT_N = 16
) (
    input logic clk,
    input logic rst_n,
    sum_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_N - 1);
    state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_WA-1:0] acc_s_q, acc_s_d;
    logic [ACC_WB-1:0] acc_t_q, acc_t_d;
    logic ovf_q, lim_q, lim_s, lim_t;
    logic [WA-1:0] s_w;
    logic [WB-1:0] t_w;
    logic hold, zero;
    assign s_w = bus.s_in;
    assign t_w = bus.t_in;
    assign hold = state_q == HOLD;
    assign zero = hold ? bus.out_ready : bus.clear;
    // accumulators are zero in IDLE, so the first sample of a block goes through the same adders
    sat_add #(.W(ACC_WA)) u_add_s (
        .acc_i(acc_s_q), .opd_i(ACC_WA'(s_w)), .sum_o(acc_s_d), .lim_o(lim_s)
    );
    sat_add #(.W(ACC_WB)) u_add_t (
        .acc_i(acc_t_q), .opd_i(ACC_WB'(t_w)), .sum_o(acc_t_d), .lim_o(lim_t)
    );
    always_ff @(posedge clk) begin
        if (!rst_n || zero) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_s_q <= '0;
            acc_t_q <= '0;
            ovf_q <= 1'b0;
            lim_q <= 1'b0;
        end else if (!hold && bus.in_valid) begin
            state_q <= cnt_q == LAST ? HOLD : ACCUM;
            cnt_q <= cnt_q + 1'b1;
            acc_s_q <= acc_s_d;
            acc_t_q <= acc_t_d;
            ovf_q <= ovf_q | bus.ovf_in;
            lim_q <= lim_q | lim_s | lim_t;
        end
    end
    assign bus.in_ready = !hold;
    assign bus.out_valid = hold;
    assign bus.acc_s = acc_s_q;
    assign bus.acc_t = acc_t_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.acc_limit = lim_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed stimulus with queued expected results checked by per-DUT monitors
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam int EXP_BT = 511;
`else
    localparam int EXP_BT = 508;
`endif
    sum_accumulator_if #(.WA(17), .WB(9), .ACC_WA(24), .ACC_WB(16)) a ();
    sum_accumulator_if #(.WA(17), .WB(9), .ACC_WA(24), .ACC_WB(9)) b ();
    sum_accumulator #(.WA(17), .WB(9), .ACC_WA(24), .ACC_WB(16), .COUNT_N(4)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a.slave)
    );
    sum_accumulator #(.WA(17), .WB(9), .ACC_WA(24), .ACC_WB(9), .COUNT_N(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
    typedef struct packed {
        logic [23:0] s;
        logic [15:0] t;
        logic o;
        logic l;
    } res_t;
    res_t qa[$];
    res_t qb[$];
    res_t ea, eb;
    int checks = 0;
    int failures = 0;

    function automatic res_t mk(input int s, input int t, input logic o, input logic l);
        mk = {24'(s), 16'(t), o, l};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [16:0] s, input logic [8:0] t, input logic o);
        int k;
        k = 0;
        a.s_in = s;
        a.t_in = t;
        a.ovf_in = o;
        a.in_valid = 1'b1;
        @(negedge clk);
        while (!a.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!a.in_ready) check("send_ready_timeout", 32'(a.in_ready), 1);
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 32'(a.out_valid), 0);
        check({tag, "_in_ready"}, 32'(a.in_ready), 1);
        check({tag, "_acc_s"}, 32'(a.acc_s), 0);
        check({tag, "_acc_t"}, 32'(a.acc_t), 0);
        check({tag, "_ovf"}, 32'(a.ovf_sticky), 0);
        check({tag, "_lim"}, 32'(a.acc_limit), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && a.out_valid && a.out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_a unexpected result acc_s=%0d acc_t=%0d", a.acc_s, a.acc_t);
            end else begin
                ea = qa.pop_front();
                check("a_acc_s", 32'(a.acc_s), 32'(ea.s));
                check("a_acc_t", 32'(a.acc_t), 32'(ea.t));
                check("a_ovf_sticky", 32'(a.ovf_sticky), 32'(ea.o));
                check("a_acc_limit", 32'(a.acc_limit), 32'(ea.l));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b.out_valid && b.out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_b unexpected result acc_s=%0d acc_t=%0d", b.acc_s, b.acc_t);
            end else begin
                eb = qb.pop_front();
                check("b_acc_s", 32'(b.acc_s), 32'(eb.s));
                check("b_acc_t", 32'(b.acc_t), 32'(eb.t));
                check("b_ovf_sticky", 32'(b.ovf_sticky), 32'(eb.o));
                check("b_acc_limit", 32'(b.acc_limit), 32'(eb.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        a.in_valid = 0; a.s_in = 0; a.t_in = 0; a.ovf_in = 0; a.clear = 0; a.out_ready = 0;
        b.in_valid = 0; b.s_in = 0; b.t_in = 0; b.ovf_in = 0; b.clear = 0; b.out_ready = 0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        step();
        // narrow T accumulator: 4 x 511 overflows 9 bits
        qb.push_back(mk(12, EXP_BT, 1'b0, 1'b1));
        b.out_ready = 1; b.s_in = 3; b.t_in = 511; b.in_valid = 1;
        repeat (4) step();
        b.in_valid = 0;
        a.out_ready = 1;
        qa.push_back(mk(4000, 40, 1'b0, 1'b0));
        repeat (4) send(1000, 10, 1'b0);
        @(negedge clk);
        check("lat_out_valid", 32'(a.out_valid), 1);
        check("hold_in_ready", 32'(a.in_ready), 0);
        @(negedge clk);
        check("post_out_valid", 32'(a.out_valid), 0);
        check("post_in_ready", 32'(a.in_ready), 1);
        step();
        qa.push_back(mk(1000, 10, 1'b1, 1'b0));
        send(100, 1, 1'b0); send(200, 2, 1'b1); send(300, 3, 1'b0); send(400, 4, 1'b0);
        qa.push_back(mk(28, 12, 1'b0, 1'b0));
        repeat (4) send(7, 3, 1'b0);
        step();
        // consumer stalls while a new sample waits
        a.out_ready = 0;
        qa.push_back(mk(200, 20, 1'b0, 1'b0));
        repeat (4) send(50, 5, 1'b0);
        a.s_in = 999; a.t_in = 1; a.ovf_in = 0; a.in_valid = 1;
        repeat (10) begin
            @(negedge clk);
            check("stall_out_valid", 32'(a.out_valid), 1);
            check("stall_in_ready", 32'(a.in_ready), 0);
            check("stall_acc_s", 32'(a.acc_s), 200);
            check("stall_acc_t", 32'(a.acc_t), 20);
        end
        qa.push_back(mk(3996, 4, 1'b0, 1'b0));
        step();
        a.out_ready = 1;
        step();
        @(negedge clk);
        check("release_in_ready", 32'(a.in_ready), 1);
        check("release_out_valid", 32'(a.out_valid), 0);
        check("release_acc_s", 32'(a.acc_s), 0);
        step();
        repeat (3) send(999, 1, 1'b0);
        step();
        // abort a partial block
        send(9, 9, 1'b0); send(9, 9, 1'b0);
        a.clear = 1; a.s_in = 100; a.in_valid = 1;
        step();
        a.clear = 0; a.in_valid = 0;
        @(negedge clk);
        check("clear_acc_s", 32'(a.acc_s), 0);
        check("clear_acc_t", 32'(a.acc_t), 0);
        check("clear_out_valid", 32'(a.out_valid), 0);
        check("clear_in_ready", 32'(a.in_ready), 1);
        step();
        qa.push_back(mk(20, 4, 1'b0, 1'b0));
        repeat (4) send(5, 1, 1'b0);
        step();
        // clear must not drop a pending result
        a.out_ready = 0;
        qa.push_back(mk(8, 8, 1'b0, 1'b0));
        repeat (4) send(2, 2, 1'b0);
        a.clear = 1;
        step();
        a.clear = 0;
        @(negedge clk);
        check("hold_clear_out_valid", 32'(a.out_valid), 1);
        check("hold_clear_acc_s", 32'(a.acc_s), 8);
        step();
        a.out_ready = 1;
        step();
        send(11, 1, 1'b1); send(11, 1, 1'b1);
        rst_n = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        check_reset_vals("rst_accum");
        step();
        a.out_ready = 0;
        repeat (4) send(3, 3, 1'b0);
        @(negedge clk);
        check("pre_rst_hold", 32'(a.out_valid), 1);
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        check_reset_vals("rst_hold");
        step();
        a.out_ready = 1;
        qa.push_back(mk(4, 4, 1'b0, 1'b0));
        repeat (4) send(1, 1, 1'b0);
        repeat (3) step();
        check("sb_a_drain", 32'(qa.size()), 0);
        check("sb_b_drain", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
